// File: rtl/cpu_pkg.sv
// Shared types, address map and region decoder for the CPU-side memory bus.
package cpu_pkg;

  typedef enum logic [1:0] {REG_EXT, REG_HRAM, REG_IE, REG_DMA} region_t;
  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_COPY} dma_state_t;

  localparam logic [15:0] ADDR_HRAM_LO = 16'hFF80;
  localparam logic [15:0] ADDR_HRAM_HI = 16'hFFFE;
  localparam logic [15:0] ADDR_IE      = 16'hFFFF;
  localparam logic [15:0] ADDR_DMA     = 16'hFF46;
  localparam logic [15:0] ADDR_OAM     = 16'hFE00;

  function automatic region_t decode_region(input logic [15:0] addr);
    if (addr == ADDR_IE) return REG_IE;
    if (addr == ADDR_DMA) return REG_DMA;
    if (addr >= ADDR_HRAM_LO && addr <= ADDR_HRAM_HI) return REG_HRAM;
    return REG_EXT;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {src_hi,00} to FE00, one byte per
// CLKS_PER_BYTE clocks, after a one-slot START delay.
module oam_dma
  import cpu_pkg::*;
#(
  parameter int DMA_LEN       = 160,
  parameter int CLKS_PER_BYTE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  start_src,
  input  logic [7:0]  ext_rd_data,
  output logic        active,
  output logic [15:0] addr,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic [7:0]  src_hi
);

  localparam logic [7:0] LAST_PHASE = 8'(CLKS_PER_BYTE - 1);
  localparam logic [7:0] LAST_BYTE  = 8'(DMA_LEN - 1);

  dma_state_t state_reg;
  logic [7:0] phase_reg;
  logic [7:0] byte_reg;
  logic [7:0] src_reg;
  logic [7:0] data_reg;
  logic       write_slot;

  // A start request wins over everything, so a re-trigger mid-copy restarts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DMA_IDLE;
      phase_reg <= '0;
      byte_reg  <= '0;
      src_reg   <= '0;
      data_reg  <= '0;
    end else if (start) begin
      state_reg <= DMA_START;
      src_reg   <= start_src;
      phase_reg <= '0;
      byte_reg  <= '0;
    end else begin
      case (state_reg)
        DMA_START: begin
          if (phase_reg == LAST_PHASE) begin
            state_reg <= DMA_COPY;
            phase_reg <= '0;
          end else begin
            phase_reg <= phase_reg + 8'd1;
          end
        end
        DMA_COPY: begin
          if (phase_reg == 8'd1) data_reg <= ext_rd_data;
          if (phase_reg == LAST_PHASE) begin
            phase_reg <= '0;
            if (byte_reg == LAST_BYTE) begin
              state_reg <= DMA_IDLE;
              byte_reg  <= '0;
            end else begin
              byte_reg <= byte_reg + 8'd1;
            end
          end else begin
            phase_reg <= phase_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign write_slot = (state_reg == DMA_COPY) && (phase_reg == 8'd2);
  assign active     = (state_reg != DMA_IDLE);
  assign wr_en      = write_slot;
  assign addr       = write_slot ? (ADDR_OAM + {8'h00, byte_reg}) : {src_reg, byte_reg};
  assign wr_data    = write_slot ? data_reg : 8'h00;
  assign src_hi     = src_reg;

endmodule

// File: rtl/bus_ctrl.sv
// CPU bus controller: HRAM, IE, FF46 DMA trigger and the external memory port,
// which the OAM DMA engine takes over while a transfer is running.
module bus_ctrl
  import cpu_pkg::*;
#(
  parameter int DMA_LEN       = 160,
  parameter int CLKS_PER_BYTE = 4,
  parameter int HRAM_DEPTH    = 127
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_cpu_rd_addr,
  output logic [7:0]  o_cpu_rd_data,
  input  logic        i_cpu_wr_en,
  input  logic [15:0] i_cpu_wr_addr,
  input  logic [7:0]  i_cpu_wr_data,
  output logic [15:0] o_ext_addr,
  output logic        o_ext_wr_en,
  output logic [7:0]  o_ext_wr_data,
  input  logic [7:0]  i_ext_rd_data,
  output logic [7:0]  o_ie,
  output logic        o_dma_active
);

  localparam int HRAM_AW = $clog2(HRAM_DEPTH);

  region_t    rd_region;
  region_t    wr_region;
  region_t    rd_region_reg;
  logic [7:0] hram_mem [0:HRAM_DEPTH-1];
  logic [7:0] hram_rd_reg;
  logic [7:0] reg_rd_reg;
  logic [7:0] ie_reg;
  logic       ext_blank_reg;

  logic        dma_start;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_wr_en;
  logic [7:0]  dma_wr_data;
  logic [7:0]  dma_src_hi;
  logic        cpu_ext_wr;

  assign rd_region  = decode_region(i_cpu_rd_addr);
  assign wr_region  = decode_region(i_cpu_wr_addr);
  assign dma_start  = i_cpu_wr_en && (wr_region == REG_DMA);
  assign cpu_ext_wr = i_cpu_wr_en && (wr_region == REG_EXT) && !dma_active;

  // HRAM is a plain RAM with registered read; its contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_cpu_wr_en && wr_region == REG_HRAM)
      hram_mem[i_cpu_wr_addr[HRAM_AW-1:0]] <= i_cpu_wr_data;
    if (rd_region == REG_HRAM)
      hram_rd_reg <= hram_mem[i_cpu_rd_addr[HRAM_AW-1:0]];
  end

  // ext_blank_reg resets high so the read port shows FF out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ie_reg        <= 8'h00;
      rd_region_reg <= REG_EXT;
      reg_rd_reg    <= 8'h00;
      ext_blank_reg <= 1'b1;
    end else begin
      if (i_cpu_wr_en && wr_region == REG_IE) ie_reg <= i_cpu_wr_data;
      rd_region_reg <= rd_region;
      reg_rd_reg    <= (rd_region == REG_IE) ? ie_reg : dma_src_hi;
      ext_blank_reg <= dma_active;
    end
  end

  always_comb begin
    case (rd_region_reg)
      REG_HRAM:        o_cpu_rd_data = hram_rd_reg;
      REG_IE, REG_DMA: o_cpu_rd_data = reg_rd_reg;
      default:         o_cpu_rd_data = ext_blank_reg ? 8'hFF : i_ext_rd_data;
    endcase
  end

  always_comb begin
    o_ext_addr    = i_cpu_rd_addr;
    o_ext_wr_en   = 1'b0;
    o_ext_wr_data = 8'h00;
    if (dma_active) begin
      o_ext_addr    = dma_addr;
      o_ext_wr_en   = dma_wr_en;
      o_ext_wr_data = dma_wr_data;
    end else if (cpu_ext_wr) begin
      o_ext_addr    = i_cpu_wr_addr;
      o_ext_wr_en   = 1'b1;
      o_ext_wr_data = i_cpu_wr_data;
    end
  end

  oam_dma #(
    .DMA_LEN       (DMA_LEN),
    .CLKS_PER_BYTE (CLKS_PER_BYTE)
  ) u_oam_dma (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .start       (dma_start),
    .start_src   (i_cpu_wr_data),
    .ext_rd_data (i_ext_rd_data),
    .active      (dma_active),
    .addr        (dma_addr),
    .wr_en       (dma_wr_en),
    .wr_data     (dma_wr_data),
    .src_hi      (dma_src_hi)
  );

  assign o_ie         = ie_reg;
  assign o_dma_active = dma_active;

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: external memory model, write monitor and
// per-feature scenario tasks compared against expectations computed here.
module tb_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rd_addr = 16'h0000;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = 16'h0000;
  logic [7:0]  wr_data = 8'h00;
  logic [7:0]  ext_rd_data;
  logic [7:0]  cpu_rd_data;
  logic [15:0] ext_addr;
  logic        ext_wr_en;
  logic [7:0]  ext_wr_data;
  logic [7:0]  ie;
  logic        dma_active;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int active_cnt = 0;
  int drop_cnt = 0;
  bit watch = 1'b0;

  bit [7:0]    ext_mem [0:65535];
  logic [15:0] mon_addr_q[$];
  logic [7:0]  mon_data_q[$];
  int          mon_cyc_q[$];
  logic [7:0]  ie_model = 8'h00;

  bus_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cpu_rd_addr (rd_addr),
    .o_cpu_rd_data (cpu_rd_data),
    .i_cpu_wr_en   (wr_en),
    .i_cpu_wr_addr (wr_addr),
    .i_cpu_wr_data (wr_data),
    .o_ext_addr    (ext_addr),
    .o_ext_wr_en   (ext_wr_en),
    .o_ext_wr_data (ext_wr_data),
    .i_ext_rd_data (ext_rd_data),
    .o_ie          (ie),
    .o_dma_active  (dma_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External memory: one-clock read latency, write on strobe.
  always @(posedge clk) begin
    ext_rd_data <= ext_mem[ext_addr];
    if (ext_wr_en) ext_mem[ext_addr] <= ext_wr_data;
  end

  always @(negedge clk) begin
    if (rst_n && ext_wr_en) begin
      mon_addr_q.push_back(ext_addr);
      mon_data_q.push_back(ext_wr_data);
      mon_cyc_q.push_back(cyc);
    end
    if (dma_active) active_cnt++;
    if (watch && !dma_active) drop_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    mon_addr_q.delete();
    mon_data_q.delete();
    mon_cyc_q.delete();
    active_cnt = 0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    rd_addr = a;
    @(posedge clk); #1;
    d = cpu_rd_data;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!dma_active) break;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s_timeout: dma_active still %b after %0d clocks, required 0", tag, dma_active, n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (2) @(negedge clk);
    checks++; if (cpu_rd_data !== 8'hFF) begin failures++; $display("FAIL reset_rd_data: got %h required ff", cpu_rd_data); end
    checks++; if (ie !== 8'h00) begin failures++; $display("FAIL reset_ie: got %h required 00", ie); end
    checks++; if (ext_wr_en !== 1'b0) begin failures++; $display("FAIL reset_ext_wr_en: got %b required 0", ext_wr_en); end
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL reset_dma_active: got %b required 0", dma_active); end
    checks++; if (ext_addr !== 16'h0000) begin failures++; $display("FAIL reset_ext_addr: got %h required 0000", ext_addr); end
    checks++; if (ext_wr_data !== 8'h00) begin failures++; $display("FAIL reset_ext_wr_data: got %h required 00", ext_wr_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    cpu_read(16'hFF46, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_ff46: got %h required 00", d); end
    $display("test_reset: done");
  endtask

  task automatic test_hram_ie();
    logic [7:0] d;
    logic [7:0] shadow [0:126];
    int idx_list [10];
    int n0;
    n0 = mon_addr_q.size();
    cpu_write(16'hFF90, 8'h5A);
    shadow[16] = 8'h5A;
    cpu_read(16'hFF90, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL hram_ff90: got %h required 5a", d); end
    cpu_write(16'hFFFF, 8'h1F);
    ie_model = 8'h1F;
    checks++; if (ie !== 8'h1F) begin failures++; $display("FAIL ie_write: got %h required 1f", ie); end
    cpu_read(16'hFFFF, d);
    checks++; if (d !== 8'h1F) begin failures++; $display("FAIL ie_read: got %h required 1f", d); end
    for (int i = 0; i < 10; i++) begin
      idx_list[i] = int'($urandom_range(0, 126));
      d = 8'($urandom);
      shadow[idx_list[i]] = d;
      cpu_write(16'hFF80 + 16'(idx_list[i]), d);
    end
    for (int i = 0; i < 10; i++) begin
      cpu_read(16'hFF80 + 16'(idx_list[i]), d);
      checks++;
      if (d !== shadow[idx_list[i]]) begin
        failures++;
        $display("FAIL hram_rand: addr %h got %h required %h", 16'hFF80 + 16'(idx_list[i]), d, shadow[idx_list[i]]);
      end
    end
    checks++;
    if (mon_addr_q.size() != n0) begin
      failures++;
      $display("FAIL internal_not_forwarded: ext writes %0d required %0d", mon_addr_q.size(), n0);
    end
    $display("test_hram_ie: done");
  endtask

  task automatic test_ext_passthrough();
    logic [7:0]  d;
    logic [15:0] addrs [6];
    logic [7:0]  sh [int];
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 16'hC000; wr_data = 8'h77;
    @(negedge clk);
    checks++;
    if (ext_wr_en !== 1'b1 || ext_addr !== 16'hC000 || ext_wr_data !== 8'h77) begin
      failures++;
      $display("FAIL ext_write: en=%b addr=%h data=%h required en=1 addr=c000 data=77", ext_wr_en, ext_addr, ext_wr_data);
    end
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk);
    checks++; if (ext_wr_en !== 1'b0) begin failures++; $display("FAIL ext_write_width: en=%b required 0", ext_wr_en); end
    cpu_read(16'hC000, d);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL ext_read_c000: got %h required 77", d); end
    for (int i = 0; i < 6; i++) begin
      addrs[i] = 16'($urandom_range(0, 16'h7FFF));
      d = 8'($urandom);
      sh[int'(addrs[i])] = d;
      cpu_write(addrs[i], d);
    end
    for (int i = 0; i < 6; i++) begin
      cpu_read(addrs[i], d);
      checks++;
      if (d !== sh[int'(addrs[i])]) begin
        failures++;
        $display("FAIL ext_rand: addr %h got %h required %h", addrs[i], d, sh[int'(addrs[i])]);
      end
    end
    $display("test_ext_passthrough: done");
  endtask

  task automatic test_full_dma();
    int bad_data, bad_gap, lim;
    logic [7:0] d;
    for (int i = 0; i < 160; i++) cpu_write(16'hC000 + 16'(i), 8'(i) ^ 8'hA5);
    clear_mon();
    cpu_write(16'hFF46, 8'hC0);
    wait_idle("full_dma");
    checks++; if (active_cnt != 644) begin failures++; $display("FAIL dma_active_len: got %0d clocks required 644", active_cnt); end
    checks++; if (mon_addr_q.size() != 160) begin failures++; $display("FAIL dma_count: got %0d writes required 160", mon_addr_q.size()); end
    lim = (mon_addr_q.size() < 160) ? mon_addr_q.size() : 160;
    bad_data = 0; bad_gap = 0;
    for (int i = 0; i < lim; i++) begin
      if (mon_addr_q[i] !== 16'hFE00 + 16'(i) || mon_data_q[i] !== (8'(i) ^ 8'hA5)) begin
        if (bad_data == 0)
          $display("FAIL dma_data: byte %0d got %h=%h required %h=%h", i, mon_addr_q[i], mon_data_q[i], 16'hFE00 + 16'(i), 8'(i) ^ 8'hA5);
        bad_data++;
      end
      if (i > 0 && mon_cyc_q[i] - mon_cyc_q[i-1] != 4) bad_gap++;
    end
    checks++; if (bad_data != 0) failures++;
    checks++; if (bad_gap != 0) begin failures++; $display("FAIL dma_spacing: %0d gaps differ from 4 clocks, required 0", bad_gap); end
    cpu_read(16'hFF46, d);
    checks++; if (d !== 8'hC0) begin failures++; $display("FAIL ff46_read: got %h required c0", d); end
    $display("test_full_dma: %0d writes over %0d active clocks", mon_addr_q.size(), active_cnt);
  endtask

  task automatic test_lockout();
    logic [7:0] d, v;
    int bad;
    clear_mon();
    cpu_write(16'hFF46, 8'hC0);
    repeat (20) @(posedge clk);
    cpu_read(16'hC123, d);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL lock_ext_read: got %h required ff", d); end
    cpu_write(16'hD000, 8'h33);
    v = 8'($urandom);
    cpu_write(16'hFF80, v);
    cpu_read(16'hFF80, d);
    checks++; if (d !== v) begin failures++; $display("FAIL lock_hram: got %h required %h", d, v); end
    cpu_read(16'hFFFF, d);
    checks++; if (d !== ie_model) begin failures++; $display("FAIL lock_ie: got %h required %h", d, ie_model); end
    checks++; if (dma_active !== 1'b1) begin failures++; $display("FAIL lock_still_active: got %b required 1", dma_active); end
    wait_idle("lockout");
    bad = 0;
    foreach (mon_addr_q[i]) if (mon_addr_q[i] < 16'hFE00 || mon_addr_q[i] > 16'hFE9F) bad++;
    checks++;
    if (bad != 0 || mon_addr_q.size() != 160) begin
      failures++;
      $display("FAIL lock_ext_writes: %0d writes, %0d outside FE00-FE9F, required 160 and 0", mon_addr_q.size(), bad);
    end
    cpu_read(16'hD000, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL lock_dropped_write: D000 got %h required 00", d); end
    $display("test_lockout: done");
  endtask

  task automatic test_restart();
    logic [7:0] dpat [160];
    int n0, n, bad;
    for (int i = 0; i < 160; i++) begin
      dpat[i] = 8'($urandom);
      cpu_write(16'hD000 + 16'(i), dpat[i]);
    end
    clear_mon();
    drop_cnt = 0;
    cpu_write(16'hFF46, 8'hC0);
    watch = 1'b1;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (mon_addr_q.size() >= 40) break;
    end
    cpu_write(16'hFF46, 8'hD0);
    n0 = mon_addr_q.size();
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (mon_addr_q.size() >= n0 + 150) break;
    end
    watch = 1'b0;
    wait_idle("restart");
    checks++; if (drop_cnt != 0) begin failures++; $display("FAIL restart_active: dropped %0d clocks, required 0", drop_cnt); end
    checks++; if (n0 != 40) begin failures++; $display("FAIL restart_first_count: got %0d writes required 40", n0); end
    checks++; if (mon_addr_q.size() != n0 + 160) begin failures++; $display("FAIL restart_total: got %0d writes required %0d", mon_addr_q.size(), n0 + 160); end
    bad = 0;
    for (int i = 0; i < mon_addr_q.size(); i++) begin
      if (i < n0) begin
        if (mon_addr_q[i] !== 16'hFE00 + 16'(i) || mon_data_q[i] !== (8'(i) ^ 8'hA5)) bad++;
      end else if (i - n0 < 160) begin
        if (mon_addr_q[i] !== 16'hFE00 + 16'(i - n0) || mon_data_q[i] !== dpat[i - n0]) bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL restart_data: %0d writes wrong, required 0", bad); end
    $display("test_restart: %0d + %0d writes", n0, mon_addr_q.size() - n0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int n, k;
    d = 8'($urandom_range(1, 255));
    cpu_write(16'hFFFF, d);
    ie_model = d;
    clear_mon();
    cpu_write(16'hFF46, 8'hC0);
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (ext_wr_en && ext_addr == 16'hFE50) break;
    end
    checks++; if (k >= 2000) begin failures++; $display("FAIL mid_reach_byte80: not reached after %0d clocks", k); end
    rst_n = 1'b0;
    #1;
    checks++; if (ext_wr_en !== 1'b0) begin failures++; $display("FAIL mid_ext_wr_en: got %b required 0", ext_wr_en); end
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL mid_dma_active: got %b required 0", dma_active); end
    checks++; if (ie !== 8'h00) begin failures++; $display("FAIL mid_ie: got %h required 00", ie); end
    n = mon_addr_q.size();
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (mon_addr_q.size() != n) begin failures++; $display("FAIL mid_no_writes: got %0d writes required %0d", mon_addr_q.size(), n); end
    cpu_read(16'hFF46, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL mid_ff46: got %h required 00", d); end
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL mid_stay_idle: got %b required 0", dma_active); end
    $display("test_reset_mid: %0d writes before reset", n);
  endtask

  initial begin
    test_reset();
    test_hram_ie();
    test_ext_passthrough();
    test_full_dma();
    test_lockout();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
